// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared types and defaults for the radix-2 restoring divider
package div_unit_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU (quotient to LO, remainder to HI)
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] num1,
    input  logic [DATA_W-1:0] num2,
    input  logic              cancel,
    output logic              busy,
    output logic              ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W:0]   prem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] divisor_q;
    logic              sign_q_q;
    logic              sign_r_q;

    logic [DATA_W-1:0] mag1, mag2;
    logic [DATA_W+1:0] shifted;
    logic [DATA_W:0]   diff;
    logic              fits;
    logic [DATA_W:0]   prem_next;
    logic [DATA_W-1:0] quo_next;
    logic [DATA_W-1:0] rem_mag;
    logic              last_step;
    logic              accept;

    // Unary minus maps 0x80000000 onto itself, which is the correct unsigned magnitude.
    assign mag1 = (is_signed && num1[DATA_W-1]) ? -num1 : num1;
    assign mag2 = (is_signed && num2[DATA_W-1]) ? -num2 : num2;

    // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
    assign shifted   = {prem_q, quo_q[DATA_W-1]};
    assign fits      = shifted >= {2'b00, divisor_q};
    assign diff      = shifted[DATA_W:0] - {1'b0, divisor_q};
    assign prem_next = fits ? diff : shifted[DATA_W:0];
    assign quo_next  = {quo_q[DATA_W-2:0], fits};
    assign rem_mag   = prem_next[DATA_W-1:0];

    assign last_step = (count_q == CNT_W'(DATA_W - 1));
    assign accept    = (state_q == S_IDLE) && start && !cancel;

    assign busy  = (state_q != S_IDLE);
    assign ready = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start && !cancel) state_d = S_DIV;
            S_DIV: begin
                if (cancel)         state_d = S_IDLE;
                else if (last_step) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            prem_q    <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            count_q   <= '0;
            prem_q    <= '0;
            quo_q     <= mag1;
            divisor_q <= mag2;
            sign_q_q  <= is_signed & (num1[DATA_W-1] ^ num2[DATA_W-1]);
            sign_r_q  <= is_signed & num1[DATA_W-1];
        end else if (state_q == S_DIV && !cancel) begin
            prem_q  <= prem_next;
            quo_q   <= quo_next;
            count_q <= count_q + 1'b1;
            // Results land on the edge into DONE so they are valid alongside ready.
            if (last_step) begin
                quotient  <= sign_q_q ? -quo_next : quo_next;
                remainder <= sign_r_q ? -rem_mag  : rem_mag;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit with directed vectors
module tb_div_unit;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk;
    logic         resetn;
    logic         start;
    logic         is_signed;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
    logic         cancel;
    logic         busy;
    logic         ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc;
    int   pass_cnt;
    int   total_cnt;

    div_unit #(.DATA_W(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .is_signed (is_signed),
        .num1      (num1),
        .num2      (num2),
        .cancel    (cancel),
        .busy      (busy),
        .ready     (ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn && ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("ready_cycle", W'(cyc), W'(e.cyc));
            end
        end
    end

    task automatic drive_start(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start     = 1'b1;
        is_signed = s;
        num1      = a;
        num2      = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Issues one operation and waits for the monitor to consume it; optionally
    // pulses a stray start at sample inject_at, which must be ignored.
    task automatic run_op(input string name, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input int inject_at);
        exp_t e;
        logic busy_ok;
        bit   done;
        busy_ok = 1'b1;
        done    = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        is_signed = s;
        num1      = a;
        num2      = b;
        e.q   = eq;
        e.r   = er;
        e.cyc = cyc + LAT;
        sb_q.push_back(e);
        for (int k = 1; k <= LAT + 20; k++) begin
            @(negedge clk);
            start = (inject_at != 0 && k == inject_at);
            if (start) begin
                num1 = 32'd50;
                num2 = 32'd5;
            end
            #1;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (sb_q.size() == 0) begin
                done = 1'b1;
                check({name, "_ready_sample"}, W'(k), W'(LAT));
                break;
            end
        end
        start = 1'b0;
        if (!done) begin
            check({name, "_timeout"}, 32'd1, 32'd0);
            sb_q.delete();
        end
        check({name, "_busy_window"}, W'(busy_ok), W'(1));
        @(negedge clk);
        #1;
        check({name, "_busy_after"}, W'(busy), W'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc       = 0;
        pass_cnt  = 0;
        total_cnt = 0;
        resetn    = 1'b0;
        start     = 1'b0;
        cancel    = 1'b0;
        is_signed = 1'b0;
        num1      = '0;
        num2      = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", W'(busy), W'(0));
        check("reset_ready", W'(ready), W'(0));
        check("reset_quotient", quotient, 32'h0);
        check("reset_remainder", remainder, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        run_op("divu_100_7",   1'b0, 32'd100,       32'd7,          32'd14,         32'd2,         0);
        run_op("div_m7_2",     1'b1, 32'hFFFFFFF9,  32'h2,          32'hFFFFFFFD,   32'hFFFFFFFF,  0);
        run_op("div_7_m2",     1'b1, 32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,         0);
        run_op("div_ovf",      1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   32'h0,         0);
        run_op("divu_max_1",   1'b0, 32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,   32'h0,         0);
        run_op("divu_5_0",     1'b0, 32'd5,         32'd0,          32'hFFFFFFFF,   32'd5,         0);
        run_op("div_m8_2",     1'b1, 32'hFFFFFFF8,  32'd2,          32'hFFFFFFFC,   32'h0,         0);

        // Cancel partway through 1000/3: no ready, outputs keep -8/2 result.
        drive_start(1'b0, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        #1;
        check("cancel_busy", W'(busy), W'(0));
        repeat (LAT + 5) @(negedge clk);
        #1;
        check("cancel_hold_q", quotient, 32'hFFFFFFFC);
        check("cancel_hold_r", remainder, 32'h0);

        run_op("divu_9_3",     1'b0, 32'd9,         32'd3,          32'd3,          32'd0,         0);

        // start together with cancel in IDLE stays idle.
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        num1   = 32'd10;
        num2   = 32'd2;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        #1;
        check("start_cancel_idle", W'(busy), W'(0));

        run_op("divu_ignore_start", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 5);

        // Asynchronous reset mid-division clears everything immediately.
        drive_start(1'b0, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midreset_busy", W'(busy), W'(0));
        check("midreset_ready", W'(ready), W'(0));
        check("midreset_q", quotient, 32'h0);
        check("midreset_r", remainder, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        run_op("divu_after_reset", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
